// File: rtl/seq_divider.sv
// Sequential unsigned divider: quotient and remainder by repeated subtraction,
// one subtraction per clock, with a start/busy/done handshake.
//
// Handshake: start is sampled only in IDLE or DONE; an accepted start latches
// dividend/divisor, which are then free to change. busy is high for every
// cycle spent in SUB. done is a one-cycle pulse in DONE and marks quotient,
// remainder and err valid; those three hold until the next completion.
// A divisor of zero skips SUB and completes with err=1, quotient=all ones,
// remainder=dividend.
module seq_divider #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      DONE = 2'd2
   } state_t;

   // FSM state is kept as a named register so checkers can bind to it.
   state_t       state;
   logic [N-1:0] rem;
   logic [N-1:0] dvs;
   logic [N-1:0] quot;

   // Single FSM: state, working registers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         rem       <= '0;
         dvs       <= '0;
         quot      <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  rem  <= dividend;
                  dvs  <= divisor;
                  quot <= '0;
                  if (divisor == '0) begin
                     // Nothing to subtract; report the error straight away.
                     state     <= DONE;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     err       <= 1'b1;
                     quotient  <= '1;
                     remainder <= dividend;
                  end else begin
                     state <= SUB;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                  end
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b0;
               end
            end
            SUB: begin
               // The >= test keeps the subtraction from underflowing, and
               // quot can never exceed the dividend, so it cannot wrap.
               if (rem >= dvs) begin
                  rem   <= rem - dvs;
                  quot  <= quot + 1'b1;
                  state <= SUB;
                  busy  <= 1'b1;
                  done  <= 1'b0;
               end else begin
                  quotient  <= quot;
                  remainder <= rem;
                  err       <= 1'b0;
                  state     <= DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus a short random run,
// with a scoreboard queue of expected results popped on each done pulse.
module tb_seq_divider;

   localparam int N = 8;
   localparam int W = 2 * N + 1 + 32;   // {quotient, remainder, err, accept_cycle}

   logic         clk;
   logic         rst;
   logic         start;
   logic [N-1:0] dividend;
   logic [N-1:0] divisor;
   logic         busy;
   logic         done;
   logic [N-1:0] quotient;
   logic [N-1:0] remainder;
   logic         err;

   logic [W-1:0] exp_q[$];
   int           n_checks;
   int           n_pass;
   int           cyc;
   int           busy_cnt;

   seq_divider #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .err       (err)
   );

   // clock / cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) if (!rst && busy) busy_cnt = busy_cnt + 1;

   // global watchdog
   initial begin
      #600000;
      $display("FAIL watchdog: got timeout, expected run to finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input longint got, input longint exp);
      n_checks = n_checks + 1;
      if (got == exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
   endtask

   // Drive a start now (caller positions us at a negedge), wait for the
   // accepting edge, then scramble the inputs and push the expected result.
   task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [N-1:0] eq;
      logic [N-1:0] er;
      logic         ee;
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = N'($urandom);
      divisor  = N'($urandom);
      if (b == '0) begin
         eq = '1; er = a; ee = 1'b1;
      end else begin
         eq = a / b; er = a % b; ee = 1'b0;
      end
      exp_q.push_back({eq, er, ee, 32'(cyc)});
   endtask

   task automatic wait_drain(input int max_cycles);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < max_cycles) begin
         @(negedge clk);
         #1;
         k++;
      end
      check_eq("drain", exp_q.size(), 0);
   endtask

   // scoreboard: compare every done pulse against the queue head
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (!rst && done) begin
         if (exp_q.size() == 0) begin
            check_eq("spurious_done", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check_eq("quotient",  quotient,  e[W-1 -: N]);
            check_eq("remainder", remainder, e[W-N-1 -: N]);
            check_eq("err",       err,       e[32]);
            check_eq("latency",   cyc - int'(e[31:0]) + 1,
                     (e[32] ? 1 : int'(e[W-1 -: N]) + 2));
         end
      end
   end

   initial begin
      n_checks = 0;
      n_pass   = 0;
      cyc      = 0;
      busy_cnt = 0;
      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_q",    quotient, 0);
      check_eq("rst_r",    remainder, 0);
      check_eq("rst_err",  err, 0);
      @(negedge clk);
      rst = 1'b0;

      // 1: 8/3
      @(negedge clk);
      busy_cnt = 0;
      issue(8'd8, 8'd3);
      wait_drain(20);
      check_eq("busy_cycles_8_3", busy_cnt, 3);

      // 2: dividend < divisor, then equal operands
      @(negedge clk);
      issue(8'd5, 8'd9);
      wait_drain(20);
      @(negedge clk);
      issue(8'd8, 8'd8);
      wait_drain(20);

      // 3: divide by zero, busy must stay low; next valid op clears err
      @(negedge clk);
      busy_cnt = 0;
      issue(8'd7, 8'd0);
      wait_drain(20);
      check_eq("busy_cycles_div0", busy_cnt, 0);
      @(negedge clk);
      issue(8'd9, 8'd2);
      wait_drain(20);

      // 4: worst case, with an ignored start mid-operation
      @(negedge clk);
      issue(8'd255, 8'd1);
      repeat (10) @(negedge clk);
      start = 1'b1; dividend = 8'd10; divisor = 8'd2;
      @(negedge clk);
      start = 1'b0;
      wait_drain(400);

      // 5: start issued in the DONE cycle
      @(negedge clk);
      issue(8'd9, 8'd4);
      begin
         int k;
         k = 0;
         do begin
            @(negedge clk);
            k++;
         end while (!done && k < 20);
         check_eq("saw_first_done", done, 1);
      end
      issue(8'd12, 8'd5);
      wait_drain(20);

      // 6: reset mid-operation aborts with zeroed outputs and no done
      @(negedge clk);
      issue(8'd200, 8'd3);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      check_eq("abort_busy", busy, 0);
      check_eq("abort_done", done, 0);
      check_eq("abort_q",    quotient, 0);
      check_eq("abort_r",    remainder, 0);
      check_eq("abort_err",  err, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);   // any done here is flagged as spurious
      issue(8'd200, 8'd3);
      wait_drain(300);

      // random operands, including zero divisors
      for (int i = 0; i < 20; i++) begin
         logic [N-1:0] a;
         logic [N-1:0] b;
         a = N'($urandom_range(0, 255));
         b = (i % 7 == 3) ? '0 : N'($urandom_range(0, 255));
         @(negedge clk);
         issue(a, b);
         wait_drain(300);
      end

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
